cpu_mem_bridge: RTL and testbench

- Sits directly downstream of the multi-cycle CPU core. Consumes its instruction request/response channels and its data memory request/response channels.
- Serialises both onto a single-ported synchronous SRAM with byte write enables and a fixed read latency.
- Returns read data to the CPU through valid/ready response channels.
- Handles one outstanding transaction at a time; the data channel has priority over the instruction channel.

---
 rtl/cpu_mem_bridge.sv | 186 ++++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_bridge
// Purpose  : Serialises the CPU instruction-fetch and data load/store
//            channels onto one single-ported synchronous SRAM with byte
//            write enables and a fixed read latency. One transaction is in
//            flight at a time; the data channel wins arbitration.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            inst_addr/inst_req_valid/   - fetch request (byte address)
//            inst_req_ready
//            inst_rdata/inst_valid/      - fetch response
//            inst_ready
//            data_addr/data_wen/data_ren/ - load/store request
//            data_wdata/data_wstrb/
//            data_req_ready
//            data_rdata/data_valid/      - load response
//            data_ready
//            sram_en/sram_we/sram_addr/  - SRAM port (word address)
//            sram_wdata/sram_rdata
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_bridge #(
   parameter int ADDR_WIDTH = 16,
   parameter int RD_LAT     = 1     // legal range 1..4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           inst_addr,
   input  logic                  inst_req_valid,
   output logic                  inst_req_ready,
   output logic [31:0]           inst_rdata,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   input  logic [31:0]           data_addr,
   input  logic                  data_wen,
   input  logic [31:0]           data_wdata,
   input  logic [3:0]            data_wstrb,
   input  logic                  data_ren,
   output logic                  data_req_ready,
   output logic [31:0]           data_rdata,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  sram_en,
   output logic [3:0]            sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   // Counter preload: WAIT lasts RD_LAT cycles, ending when the count is 0.
   localparam logic [1:0] c_cnt_init = 2'(RD_LAT - 1);

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic [3:0]            r_wstrb;
   logic                  r_is_wr;
   logic                  r_src_data;
   logic                  r_inst_valid;
   logic                  r_data_valid;
   logic [31:0]           r_inst_rdata;
   logic [31:0]           r_data_rdata;

   logic                  w_idle;
   logic                  w_data_req;
   logic                  w_accept;
   logic                  w_capture;
   logic                  w_resp_done;
   logic                  w_sram_en;
   logic [3:0]            w_sram_we;
   logic                  w_unused;

   // Only the word-address bits of the byte addresses reach the SRAM; the
   // remaining bits are deliberately dropped so large addresses alias.
   assign w_unused = ^{inst_addr, data_addr};

   // Arbitration: any data request (load or store) beats a fetch.
   assign w_idle         = (r_state == ST_IDLE) && !rst;
   assign w_data_req     = data_wen | data_ren;
   assign data_req_ready = w_idle & w_data_req;
   assign inst_req_ready = w_idle & inst_req_valid & ~w_data_req;
   assign w_accept       = data_req_ready | inst_req_ready;

   // Last WAIT cycle: SRAM read data is valid on sram_rdata now.
   assign w_capture   = (r_state == ST_WAIT) && (r_cnt == 2'd0);
   assign w_resp_done = (r_state == ST_RESP) &&
                        (r_src_data ? (r_data_valid & data_ready)
                                    : (r_inst_valid & inst_ready));

   always_comb begin
      w_next    = r_state;
      w_sram_en = 1'b0;
      w_sram_we = 4'b0000;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next = ST_ACCESS;
         end
         ST_ACCESS: begin
            w_sram_en = 1'b1;
            if (r_is_wr) begin
               // A zero strobe still occupies the slot, writing nothing.
               w_sram_we = r_wstrb;
               w_next    = ST_IDLE;
            end else begin
               w_next    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_cnt == 2'd0) w_next = ST_RESP;
         end
         ST_RESP: begin
            if (w_resp_done) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 2'd0;
         r_addr       <= '0;
         r_wdata      <= 32'd0;
         r_wstrb      <= 4'd0;
         r_is_wr      <= 1'b0;
         r_src_data   <= 1'b0;
         r_inst_valid <= 1'b0;
         r_data_valid <= 1'b0;
         r_inst_rdata <= 32'd0;
         r_data_rdata <= 32'd0;
      end else begin
         r_state <= w_next;

         if (w_accept) begin
            r_addr     <= data_req_ready ? data_addr[ADDR_WIDTH+1:2]
                                         : inst_addr[ADDR_WIDTH+1:2];
            r_wdata    <= data_wdata;
            r_wstrb    <= data_wstrb;
            // Store wins when the CPU raises both wen and ren.
            r_is_wr    <= data_req_ready & data_wen;
            r_src_data <= data_req_ready;
         end

         if ((r_state == ST_ACCESS) && !r_is_wr) begin
            r_cnt <= c_cnt_init;
         end else if ((r_state == ST_WAIT) && (r_cnt != 2'd0)) begin
            r_cnt <= r_cnt - 2'd1;
         end

         if (w_capture) begin
            if (r_src_data) begin
               r_data_rdata <= sram_rdata;
               r_data_valid <= 1'b1;
            end else begin
               r_inst_rdata <= sram_rdata;
               r_inst_valid <= 1'b1;
            end
         end

         if (w_resp_done) begin
            r_inst_valid <= 1'b0;
            r_data_valid <= 1'b0;
         end
      end
   end

   assign sram_en    = w_sram_en;
   assign sram_we    = w_sram_we;
   assign sram_addr  = r_addr;
   assign sram_wdata = r_wdata;
   assign inst_valid = r_inst_valid;
   assign inst_rdata = r_inst_rdata;
   assign data_valid = r_data_valid;
   assign data_rdata = r_data_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_bridge
// Purpose  : Self-checking bench for cpu_mem_bridge. Two bridges are built,
//            one with RD_LAT=1 and one with RD_LAT=3, each driving its own
//            behavioural SRAM. A vector table of stores/loads runs on both,
//            followed by hand-written arbitration, back-pressure and reset
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_bridge;

   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          inst_req_valid [2];
   logic          inst_ready     [2];
   logic          data_wen       [2];
   logic          data_ren       [2];
   logic          data_ready     [2];
   logic [31:0]   inst_addr      [2];
   logic [31:0]   data_addr      [2];
   logic [31:0]   data_wdata     [2];
   logic [3:0]    data_wstrb     [2];
   logic          inst_req_ready [2];
   logic          data_req_ready [2];
   logic          inst_valid     [2];
   logic          data_valid     [2];
   logic [31:0]   inst_rdata     [2];
   logic [31:0]   data_rdata     [2];
   logic          sram_en        [2];
   logic [3:0]    sram_we        [2];
   logic [AW-1:0] sram_addr      [2];
   logic [31:0]   sram_wdata     [2];
   logic [31:0]   sram_rdata     [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : 3;

      // Behavioural SRAM: read data appears exactly LAT cycles after the
      // enable cycle and is garbage at any other time.
      logic [31:0] mem  [0:(1<<AW)-1];
      logic [31:0] pipe [4];
      logic [3:0]  pv = 4'b0000;

      always @(posedge clk) begin
         if (sram_en[g]) begin
            for (int b = 0; b < 4; b++) begin
               if (sram_we[g][b]) mem[sram_addr[g]][8*b +: 8] <= sram_wdata[g][8*b +: 8];
            end
         end
         pipe[0] <= mem[sram_addr[g]];
         pv[0]   <= sram_en[g] && (sram_we[g] == 4'b0000);
         for (int i = 1; i < 4; i++) begin
            pipe[i] <= pipe[i-1];
            pv[i]   <= pv[i-1];
         end
      end
      assign sram_rdata[g] = pv[LAT-1] ? pipe[LAT-1] : 32'hDEADBEEF;

      cpu_mem_bridge #(.ADDR_WIDTH(AW), .RD_LAT(LAT)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .inst_addr     (inst_addr[g]),
         .inst_req_valid(inst_req_valid[g]),
         .inst_req_ready(inst_req_ready[g]),
         .inst_rdata    (inst_rdata[g]),
         .inst_valid    (inst_valid[g]),
         .inst_ready    (inst_ready[g]),
         .data_addr     (data_addr[g]),
         .data_wen      (data_wen[g]),
         .data_wdata    (data_wdata[g]),
         .data_wstrb    (data_wstrb[g]),
         .data_ren      (data_ren[g]),
         .data_req_ready(data_req_ready[g]),
         .data_rdata    (data_rdata[g]),
         .data_valid    (data_valid[g]),
         .data_ready    (data_ready[g]),
         .sram_en       (sram_en[g]),
         .sram_we       (sram_we[g]),
         .sram_addr     (sram_addr[g]),
         .sram_wdata    (sram_wdata[g]),
         .sram_rdata    (sram_rdata[g])
      );
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] waddr(input logic [31:0] a);
      logic [31:0] w;
      w = {16'd0, a[AW+1:2]};
      return w;
   endfunction

   // Poll the request-ready line; the caller has just driven a request.
   task automatic wait_req_ready(input int k, input bit is_data, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (is_data ? data_req_ready[k] : inst_req_ready[k]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_store(input int k, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st);
      bit ok;
      @(negedge clk);
      data_addr[k]  = addr;
      data_wdata[k] = wd;
      data_wstrb[k] = st;
      data_wen[k]   = 1'b1;
      wait_req_ready(k, 1'b1, ok);
      chk("st_accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1 data_wen[k] = 1'b0;
      @(negedge clk);
      chk("st_en",    {31'd0, sram_en[k]}, 32'd1);
      chk("st_we",    {28'd0, sram_we[k]}, {28'd0, st});
      chk("st_addr",  {16'd0, sram_addr[k]}, waddr(addr));
      chk("st_wdata", sram_wdata[k], wd);
      @(negedge clk);
      chk("st_en_off", {31'd0, sram_en[k]}, 32'd0);
   endtask

   task automatic do_load(input int k, input bit is_inst, input logic [31:0] addr,
                          input logic [31:0] exp, input int hold);
      bit ok;
      int n;
      logic v;
      @(negedge clk);
      if (is_inst) begin
         inst_addr[k] = addr; inst_req_valid[k] = 1'b1;
      end else begin
         data_addr[k] = addr; data_ren[k] = 1'b1;
      end
      wait_req_ready(k, !is_inst, ok);
      chk("ld_accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1;
      inst_req_valid[k] = 1'b0;
      data_ren[k]       = 1'b0;
      n = 0;
      v = 1'b0;
      while (n < 20 && !v) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk("ld_en",   {31'd0, sram_en[k]}, 32'd1);
            chk("ld_we",   {28'd0, sram_we[k]}, 32'd0);
            chk("ld_addr", {16'd0, sram_addr[k]}, waddr(addr));
         end else if (sram_en[k]) begin
            chk("ld_extra_en", {31'd0, sram_en[k]}, 32'd0);
         end
         v = is_inst ? inst_valid[k] : data_valid[k];
      end
      chk("ld_latency", n, 2 + lat_of(k));
      chk("ld_rdata", is_inst ? inst_rdata[k] : data_rdata[k], exp);
      chk("ld_other_valid", {31'd0, is_inst ? data_valid[k] : inst_valid[k]}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, is_inst ? inst_valid[k] : data_valid[k]}, 32'd1);
         chk("bp_rdata", is_inst ? inst_rdata[k] : data_rdata[k], exp);
         chk("bp_no_en", {31'd0, sram_en[k]}, 32'd0);
      end
      if (is_inst) inst_ready[k] = 1'b1; else data_ready[k] = 1'b1;
      @(negedge clk);
      chk("ld_valid_drop", {31'd0, is_inst ? inst_valid[k] : data_valid[k]}, 32'd0);
      inst_ready[k] = 1'b0;
      data_ready[k] = 1'b0;
   endtask

   typedef struct {
      bit          is_st;
      bit          is_inst;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [13];

   initial begin
      bit   ok;
      int   n;
      logic seen;

      tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h3C01_0001, 4'b1111, 32'h0};
      tbl[1]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         4'b0000, 32'h3C01_0001};
      tbl[2]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h1122_3344, 4'b1111, 32'h0};
      tbl[3]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h0000_AB00, 4'b0010, 32'h0};
      tbl[4]  = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 32'h1122_AB44};
      tbl[5]  = '{1'b1, 1'b0, 32'h0000_0108, 32'hAABB_CCDD, 4'b1111, 32'h0};
      tbl[6]  = '{1'b1, 1'b0, 32'h0000_0108, 32'hFFFF_FFFF, 4'b0000, 32'h0};
      tbl[7]  = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,         4'b0000, 32'hAABB_CCDD};
      tbl[8]  = '{1'b0, 1'b1, 32'h0004_0106, 32'h0,         4'b0000, 32'h1122_AB44};
      tbl[9]  = '{1'b1, 1'b0, 32'h0000_0104, 32'h5500_0000, 4'b1000, 32'h0};
      tbl[10] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 32'h5522_AB44};
      tbl[11] = '{1'b1, 1'b0, 32'h0003_FFFC, 32'hCAFE_F00D, 4'b1111, 32'h0};
      tbl[12] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'b0000, 32'hCAFE_F00D};

      for (int k = 0; k < 2; k++) begin
         inst_req_valid[k] = 1'b0; inst_ready[k] = 1'b0;
         data_wen[k] = 1'b0; data_ren[k] = 1'b0; data_ready[k] = 1'b0;
         inst_addr[k] = 32'd0; data_addr[k] = 32'd0;
         data_wdata[k] = 32'd0; data_wstrb[k] = 4'd0;
      end

      // Reset with a fetch pending: nothing may be accepted or driven.
      rst = 1'b1;
      inst_req_valid[0] = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk("rst_inst_rdy", {31'd0, inst_req_ready[0]}, 32'd0);
         chk("rst_ivalid",   {31'd0, inst_valid[0]}, 32'd0);
         chk("rst_dvalid",   {31'd0, data_valid[0]}, 32'd0);
         chk("rst_en",       {31'd0, sram_en[0]}, 32'd0);
         chk("rst_we",       {28'd0, sram_we[0]}, 32'd0);
         chk("rst_addr",     {16'd0, sram_addr[0]}, 32'd0);
      end
      rst = 1'b0;
      #1;
      chk("post_rst_inst_rdy", {31'd0, inst_req_ready[0]}, 32'd1);
      chk("post_rst_data_rdy", {31'd0, data_req_ready[0]}, 32'd0);
      inst_req_valid[0] = 1'b0;

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 13; i++) begin
            if (tbl[i].is_st) do_store(k, tbl[i].addr, tbl[i].wdata, tbl[i].strb);
            else              do_load(k, tbl[i].is_inst, tbl[i].addr, tbl[i].exp, 0);
         end
      end

      // wen and ren together: treated as a store, no read response.
      @(negedge clk);
      data_addr[0] = 32'h200; data_wdata[0] = 32'h1234_5678; data_wstrb[0] = 4'hF;
      data_wen[0] = 1'b1; data_ren[0] = 1'b1;
      wait_req_ready(0, 1'b1, ok);
      chk("both_accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1 data_wen[0] = 1'b0; data_ren[0] = 1'b0;
      @(negedge clk);
      chk("both_we", {28'd0, sram_we[0]}, 32'hF);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | data_valid[0];
      end
      chk("both_no_resp", {31'd0, seen}, 32'd0);
      do_load(0, 1'b0, 32'h200, 32'h1234_5678, 0);

      // Simultaneous fetch and load: data first, fetch right after.
      @(negedge clk);
      inst_addr[0] = 32'h0; inst_req_valid[0] = 1'b1;
      data_addr[0] = 32'h108; data_ren[0] = 1'b1;
      #1;
      chk("arb_data_rdy", {31'd0, data_req_ready[0]}, 32'd1);
      chk("arb_inst_rdy", {31'd0, inst_req_ready[0]}, 32'd0);
      @(posedge clk);
      #1 data_ren[0] = 1'b0;
      n = 0;
      while (n < 20 && !data_valid[0]) begin
         @(negedge clk);
         n++;
         chk("arb_busy_inst_rdy", {31'd0, inst_req_ready[0]}, 32'd0);
      end
      chk("arb_data_lat", n, 3);
      chk("arb_data", data_rdata[0], 32'hAABB_CCDD);
      data_ready[0] = 1'b1;
      @(negedge clk);
      data_ready[0] = 1'b0;
      #1;
      chk("arb_data_drop", {31'd0, data_valid[0]}, 32'd0);
      chk("arb_inst_accept", {31'd0, inst_req_ready[0]}, 32'd1);
      @(posedge clk);
      #1 inst_req_valid[0] = 1'b0;
      n = 0;
      while (n < 20 && !inst_valid[0]) begin
         @(negedge clk);
         n++;
      end
      chk("arb_inst_lat", n, 3);
      chk("arb_inst", inst_rdata[0], 32'h3C01_0001);
      inst_ready[0] = 1'b1;
      @(negedge clk);
      chk("arb_inst_drop", {31'd0, inst_valid[0]}, 32'd0);
      inst_ready[0] = 1'b0;

      // Back-pressure on the RD_LAT=3 bridge.
      do_load(1, 1'b0, 32'h104, 32'h5522_AB44, 5);

      // Reset during WAIT on the RD_LAT=3 bridge drops the fetch.
      @(negedge clk);
      inst_addr[1] = 32'h0; inst_req_valid[1] = 1'b1;
      wait_req_ready(1, 1'b0, ok);
      chk("mid_accept", {31'd0, ok}, 32'd1);
      @(posedge clk);
      #1 inst_req_valid[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | inst_valid[1] | data_valid[1] | sram_en[1];
      end
      chk("mid_rst_quiet", {31'd0, seen}, 32'd0);
      do_load(1, 1'b1, 32'h0, 32'h3C01_0001, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
